// File: rtl/minimig_bankarb_pkg.sv
// Shared encodings for the Minimig SDRAM bank arbiter.
// Grant codes, FSM states and the power-on memory configuration.
package minimig_bankarb_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DMA  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_HOST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] CFG_RESET = 4'b0000;

endpackage

// File: rtl/minimig_bankarb_prio.sv
// Combinational winner pick for the bank arbiter.
// Starved CPU first, then DMA, then CPU/host round-robin.
module minimig_bankarb_prio
    import minimig_bankarb_pkg::*;
(
    input  logic       dma_req,
    input  logic       cpu_req,
    input  logic       host_req,
    input  logic       cpu_starved,
    input  logic       rr_last_host,
    output logic [1:0] winner
);

    always_comb begin
        winner = GNT_NONE;
        if (cpu_req && cpu_starved)
            winner = GNT_CPU;
        else if (dma_req)
            winner = GNT_DMA;
        else if (cpu_req && host_req)
            winner = rr_last_host ? GNT_CPU : GNT_HOST;
        else if (cpu_req)
            winner = GNT_CPU;
        else if (host_req)
            winner = GNT_HOST;
    end

endmodule

// File: rtl/minimig_bank_arbiter.sv
// SDRAM port arbiter for chipset DMA, CPU and host/RTG requesters.
// Optional WAIT watchdog: define MINIMIG_BANKARB_TIMEOUT_EN.
module minimig_bank_arbiter
    import minimig_bankarb_pkg::*;
#(
    parameter int RECOVERY_CYCLES = 1,
    parameter int STARVE_LIMIT    = 4,
    parameter int TIMEOUT_CYCLES  = 255
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_wr,
    input  logic [3:0] cfg_memory_config,
    output logic [3:0] active_config,
    input  logic       dma_req,
    input  logic       cpu_req,
    input  logic       host_req,
    input  logic [7:0] dma_bank,
    input  logic [7:0] cpu_bank,
    input  logic [7:0] host_bank,
    input  logic       dma_we,
    input  logic       cpu_we,
    input  logic       host_we,
    output logic       dma_ack,
    output logic       cpu_ack,
    output logic       host_ack,
    output logic       ram_req,
    output logic [7:0] ram_bank,
    output logic       ram_we,
    input  logic       ram_ack,
    output logic [1:0] grant,
`ifdef MINIMIG_BANKARB_TIMEOUT_EN
    output logic       timeout_flag,
`endif
    output logic       err_nobank
);

    localparam logic [2:0] REC_LAST =
        3'(RECOVERY_CYCLES == 0 ? 0 : RECOVERY_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam state_t POST_ST =
        (RECOVERY_CYCLES == 0) ? ST_IDLE : ST_RECOVER;

    state_t     state, state_nxt;
    logic [1:0] winner;
    logic [7:0] win_bank;
    logic       win_we;
    logic [2:0] rec_cnt;
    logic [3:0] starve_cnt;
    logic       rr_last_host;
    logic [3:0] pend_cfg;
    logic       pend_vld;
    logic       wait_done;
    logic       timeout_hit;
    logic       dma_r, cpu_r, host_r;

    // A requester still sees its req high during its ack cycle; mask it
    // so a zero-recovery build cannot grant the same access twice.
    assign dma_r  = dma_req  & ~dma_ack;
    assign cpu_r  = cpu_req  & ~cpu_ack;
    assign host_r = host_req & ~host_ack;

    minimig_bankarb_prio u_prio (
        .dma_req      (dma_r),
        .cpu_req      (cpu_r),
        .host_req     (host_r),
        .cpu_starved  (starve_cnt == STARVE_MAX),
        .rr_last_host (rr_last_host),
        .winner       (winner)
    );

    always_comb begin
        win_bank = 8'h00;
        win_we   = 1'b0;
        case (winner)
            GNT_DMA:  begin win_bank = dma_bank;  win_we = dma_we;  end
            GNT_CPU:  begin win_bank = cpu_bank;  win_we = cpu_we;  end
            GNT_HOST: begin win_bank = host_bank; win_we = host_we; end
            default:  ;
        endcase
    end

`ifdef MINIMIG_BANKARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wt_cnt;

    assign timeout_hit = (wt_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_cnt       <= 8'd0;
            timeout_flag <= 1'b0;
        end else if (state == ST_WAIT) begin
            wt_cnt <= wt_cnt + 8'd1;
            if (!ram_ack && timeout_hit)
                timeout_flag <= 1'b1;
        end else begin
            wt_cnt <= 8'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign wait_done = ram_ack | timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (winner != GNT_NONE)
                    state_nxt = (win_bank == 8'h00) ? POST_ST : ST_WAIT;
            ST_WAIT:
                if (wait_done)
                    state_nxt = POST_ST;
            ST_RECOVER:
                if (rec_cnt == REC_LAST)
                    state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_config <= CFG_RESET;
            pend_cfg      <= CFG_RESET;
            pend_vld      <= 1'b0;
            dma_ack       <= 1'b0;
            cpu_ack       <= 1'b0;
            host_ack      <= 1'b0;
            ram_req       <= 1'b0;
            ram_bank      <= 8'h00;
            ram_we        <= 1'b0;
            grant         <= GNT_NONE;
            err_nobank    <= 1'b0;
            rec_cnt       <= 3'd0;
            starve_cnt    <= 4'd0;
            rr_last_host  <= 1'b1;
        end else begin
            dma_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            host_ack <= 1'b0;
            rec_cnt  <= 3'd0;
            if (cfg_wr) begin
                pend_cfg <= cfg_memory_config;
                pend_vld <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (winner == GNT_NONE) begin
                        if (!cpu_req)
                            starve_cnt <= 4'd0;
                        // Only an idle bus may switch the mapper config.
                        if (pend_vld) begin
                            active_config <= pend_cfg;
                            if (!cfg_wr)
                                pend_vld <= 1'b0;
                        end
                    end else begin
                        if (win_bank == 8'h00) begin
                            err_nobank <= 1'b1;
                            dma_ack    <= (winner == GNT_DMA);
                            cpu_ack    <= (winner == GNT_CPU);
                            host_ack   <= (winner == GNT_HOST);
                        end else begin
                            ram_req  <= 1'b1;
                            ram_bank <= win_bank;
                            ram_we   <= win_we;
                            grant    <= winner;
                        end
                        if (winner == GNT_DMA && cpu_req) begin
                            if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 4'd1;
                        end else if (winner == GNT_CPU || !cpu_req) begin
                            starve_cnt <= 4'd0;
                        end
                        if (winner == GNT_CPU)
                            rr_last_host <= 1'b0;
                        else if (winner == GNT_HOST)
                            rr_last_host <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        ram_req  <= 1'b0;
                        grant    <= GNT_NONE;
                        dma_ack  <= (grant == GNT_DMA);
                        cpu_ack  <= (grant == GNT_CPU);
                        host_ack <= (grant == GNT_HOST);
                    end
                end
                ST_RECOVER:
                    rec_cnt <= rec_cnt + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minimig_bank_arbiter.sv
// Scoreboard bench for minimig_bank_arbiter: directed requester
// scenarios, a simple SDRAM responder and a decoupled monitor.
module tb_minimig_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_wr;
    logic [3:0] cfg_memory_config;
    logic [3:0] active_config;
    logic       dma_req, cpu_req, host_req;
    logic [7:0] dma_bank, cpu_bank, host_bank;
    logic       dma_we, cpu_we, host_we;
    logic       dma_ack, cpu_ack, host_ack;
    logic       ram_req;
    logic [7:0] ram_bank;
    logic       ram_we;
    logic       ram_ack;
    logic [1:0] grant;
    logic       err_nobank;
`ifdef MINIMIG_BANKARB_TIMEOUT_EN
    logic       timeout_flag;
`endif

    int total = 0;
    int bad   = 0;

    logic [10:0] txq[$];
    logic [2:0]  ackq[$];

    logic resp_en    = 1'b1;
    int   resp_delay = 3;

    always #5 clk = ~clk;

    minimig_bank_arbiter #(
        .RECOVERY_CYCLES (1),
        .STARVE_LIMIT    (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_wr            (cfg_wr),
        .cfg_memory_config (cfg_memory_config),
        .active_config     (active_config),
        .dma_req           (dma_req),
        .cpu_req           (cpu_req),
        .host_req          (host_req),
        .dma_bank          (dma_bank),
        .cpu_bank          (cpu_bank),
        .host_bank         (host_bank),
        .dma_we            (dma_we),
        .cpu_we            (cpu_we),
        .host_we           (host_we),
        .dma_ack           (dma_ack),
        .cpu_ack           (cpu_ack),
        .host_ack          (host_ack),
        .ram_req           (ram_req),
        .ram_bank          (ram_bank),
        .ram_we            (ram_we),
        .ram_ack           (ram_ack),
        .grant             (grant),
`ifdef MINIMIG_BANKARB_TIMEOUT_EN
        .timeout_flag      (timeout_flag),
`endif
        .err_nobank        (err_nobank)
    );

    // SDRAM model: ack after resp_delay cycles of ram_req
    initial begin
        int rcnt;
        rcnt = 0;
        ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            if (resp_en && ram_req && !reset) begin
                rcnt++;
                if (rcnt == resp_delay) begin
                    ram_ack = 1'b1;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new ram_req and each ack pulse
    initial begin
        logic        prev_req;
        logic [10:0] etx;
        logic [2:0]  eack;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ram_req && !prev_req) begin
                    total++;
                    if (txq.size() == 0) begin
                        bad++;
                        $display("FAIL txn_unexpected got g=%0d bank=%h we=%0d",
                                 grant, ram_bank, ram_we);
                    end else begin
                        etx = txq.pop_front();
                        if ({grant, ram_bank, ram_we} !== etx) begin
                            bad++;
                            $display("FAIL txn got g=%0d bank=%h we=%0d want g=%0d bank=%h we=%0d",
                                     grant, ram_bank, ram_we,
                                     etx[10:9], etx[8:1], etx[0]);
                        end
                    end
                end
                if (dma_ack || cpu_ack || host_ack) begin
                    total++;
                    if (ackq.size() == 0) begin
                        bad++;
                        $display("FAIL ack_unexpected got %b",
                                 {dma_ack, cpu_ack, host_ack});
                    end else begin
                        eack = ackq.pop_front();
                        if ({dma_ack, cpu_ack, host_ack} !== eack) begin
                            bad++;
                            $display("FAIL ack got %b want %b",
                                     {dma_ack, cpu_ack, host_ack}, eack);
                        end
                    end
                end
            end
            prev_req = ram_req;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // which: 2=dma 1=cpu 0=host
    task automatic wait_ack(input int which, input int lim);
        logic [2:0] a;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            a = {dma_ack, cpu_ack, host_ack};
            if (a[which]) return;
        end
        total++;
        bad++;
        $display("FAIL wait_ack_timeout which=%0d", which);
    endtask

    task automatic wait_n_acks(input int n, input int lim);
        int seen;
        seen = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (dma_ack || cpu_ack || host_ack) seen++;
            if (seen == n) return;
        end
        total++;
        bad++;
        $display("FAIL wait_n_acks_timeout seen=%0d want=%0d", seen, n);
    endtask

    task automatic wait_req_high(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ram_req) return;
        end
        total++;
        bad++;
        $display("FAIL wait_req_timeout");
    endtask

    initial begin
        reset = 1'b1;
        cfg_wr = 1'b0;
        cfg_memory_config = 4'h0;
        dma_req = 0; cpu_req = 0; host_req = 0;
        dma_bank = 0; cpu_bank = 0; host_bank = 0;
        dma_we = 0; cpu_we = 0; host_we = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_grant", grant, 0);
        chk("rst_active_config", active_config, 0);
        chk("rst_err_nobank", err_nobank, 0);
        chk("rst_ram_bank", ram_bank, 0);
        chk("rst_acks", {dma_ack, cpu_ack, host_ack}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: DMA and CPU together, DMA served first then CPU
        dma_bank = 8'h11; dma_we = 1;
        cpu_bank = 8'h22; cpu_we = 0;
        resp_delay = 3;
        txq.push_back({2'd1, 8'h11, 1'b1});
        ackq.push_back(3'b100);
        txq.push_back({2'd2, 8'h22, 1'b0});
        ackq.push_back(3'b010);
        dma_req = 1; cpu_req = 1;
        wait_ack(2, 50);
        dma_req = 0;
        wait_ack(1, 50);
        cpu_req = 0;
        repeat (3) @(negedge clk);

        // 2: DMA held with CPU waiting: 4 DMA grants then CPU
        dma_bank = 8'h33; dma_we = 1;
        cpu_bank = 8'h44; cpu_we = 0;
        for (int i = 0; i < 4; i++) begin
            txq.push_back({2'd1, 8'h33, 1'b1});
            ackq.push_back(3'b100);
        end
        txq.push_back({2'd2, 8'h44, 1'b0});
        ackq.push_back(3'b010);
        dma_req = 1; cpu_req = 1;
        wait_ack(1, 200);
        dma_req = 0; cpu_req = 0;
        repeat (3) @(negedge clk);

        // 3: CPU and host held; last grant was CPU so host leads
        cpu_bank = 8'h55; cpu_we = 0;
        host_bank = 8'h66; host_we = 1;
        for (int i = 0; i < 2; i++) begin
            txq.push_back({2'd3, 8'h66, 1'b1});
            ackq.push_back(3'b001);
            txq.push_back({2'd2, 8'h55, 1'b0});
            ackq.push_back(3'b010);
        end
        cpu_req = 1; host_req = 1;
        wait_n_acks(4, 200);
        cpu_req = 0; host_req = 0;
        repeat (3) @(negedge clk);

        // 4: config write during WAIT applies at first idle no-winner cycle
        dma_bank = 8'h77; dma_we = 0;
        resp_delay = 5;
        txq.push_back({2'd1, 8'h77, 1'b0});
        ackq.push_back(3'b100);
        dma_req = 1;
        wait_req_high(20);
        cfg_wr = 1; cfg_memory_config = 4'b0011;
        @(negedge clk);
        cfg_wr = 0;
        chk("cfg_in_wait", active_config, 0);
        wait_ack(2, 50);
        chk("cfg_at_ack", active_config, 0);
        dma_req = 0;
        @(negedge clk);
        chk("cfg_in_recover", active_config, 0);
        @(negedge clk);
        chk("cfg_applied", active_config, 3);
        resp_delay = 3;
        repeat (2) @(negedge clk);

        // 5: zero bank select from CPU
        cpu_bank = 8'h00;
        ackq.push_back(3'b010);
        cpu_req = 1;
        wait_ack(1, 20);
        chk("nobank_ram_req", ram_req, 0);
        chk("nobank_grant", grant, 0);
        chk("nobank_err", err_nobank, 1);
        cpu_req = 0;
        repeat (3) @(negedge clk);
        chk("nobank_err_sticky", err_nobank, 1);

        // 6: reset mid-WAIT
        resp_en = 0;
        dma_bank = 8'h88; dma_we = 0;
        txq.push_back({2'd1, 8'h88, 1'b0});
        dma_req = 1;
        wait_req_high(20);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rstwait_ram_req", ram_req, 0);
        chk("rstwait_grant", grant, 0);
        chk("rstwait_acks", {dma_ack, cpu_ack, host_ack}, 0);
        chk("rstwait_err", err_nobank, 0);
        chk("rstwait_cfg", active_config, 0);
        dma_req = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_ram_req", ram_req, 0);
        resp_en = 1;

`ifdef MINIMIG_BANKARB_TIMEOUT_EN
        begin
            int n;
            resp_en = 0;
            dma_bank = 8'h99; dma_we = 1;
            txq.push_back({2'd1, 8'h99, 1'b1});
            ackq.push_back(3'b100);
            dma_req = 1;
            wait_req_high(20);
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                n++;
                if (dma_ack) break;
            end
            chk("timeout_cycles", n, 8);
            chk("timeout_flag", timeout_flag, 1);
            dma_req = 0;
            resp_en = 1;
            repeat (3) @(negedge clk);
        end
`endif

        chk("txq_drained", txq.size(), 0);
        chk("ackq_drained", ackq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
